mdu_controller: RTL and testbench

Multi-cycle controller and datapath for the RV32M multiply/divide instructions in the EX stage of the xgriscv pipeline. It extends the single-cycle decode control with an iterative sequencer. The block decodes the M-extension encoding, computes the result using shift-add multiplication or restoring division, and stalls the pipeline until the result is ready. The width is parametrised and an optional single-cycle multiply mode is provided.

---
 rtl/mdu_if.sv | 24 ++
 rtl/mdu_controller.sv | 135 +++++++++++++
 tb/tb_mdu_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// EX-stage handshake between the pipeline and the RV32M multiply/divide unit.
interface mdu_if #(parameter int XLEN = 32);
  logic            valid_in;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            is_mdu;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output valid_in, opcode, funct3, funct7, srca, srcb, flush,
    input  is_mdu, stall, done, result
  );

  modport slave (
    input  valid_in, opcode, funct3, funct7, srca, srcb, flush,
    output is_mdu, stall, done, result
  );
endinterface

// File: rtl/mdu_controller.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide,
// optional single-cycle multiply, pipeline stall until the result is ready.
module mdu_controller #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   prod_p0;
  logic [XLEN:0]       rem_p0;
  logic [XLEN-1:0]     bmag_p0;
  logic [2:0]          f3_p0;
  logic                neg_q_p0;
  logic                neg_r_p0;
  logic [XLEN-1:0]     result_p1;

  logic                issue, a_signed, b_signed, a_neg, b_neg;
  logic                div_zero, div_ovf, fast_mul;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic signed [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  logic [XLEN:0]       mul_sum, div_shift, div_diff, rem_next;
  logic [2*XLEN-1:0]   prod_next;

  // Signs are applied once at the end, so the datapath only ever sees magnitudes.
  function automatic logic [XLEN-1:0] finish_op(input logic [2:0] f3,
                                               input logic [2*XLEN-1:0] p,
                                               input logic [XLEN:0] r,
                                               input logic nq, input logic nr);
    logic [2*XLEN-1:0] ps;
    ps = nq ? -p : p;
    if (!f3[2])      return (f3 == 3'b000) ? ps[XLEN-1:0] : ps[2*XLEN-1:XLEN];
    else if (!f3[1]) return nq ? -p[XLEN-1:0] : p[XLEN-1:0];
    else             return nr ? -r[XLEN-1:0] : r[XLEN-1:0];
  endfunction

  assign bus.is_mdu = (bus.opcode == 7'b0110011) && (bus.funct7 == 7'b0000001);
  assign issue      = (state == IDLE) && bus.valid_in && bus.is_mdu && !bus.flush;
  assign bus.stall  = (state == RUN) || issue;
  assign bus.done   = (state == DONE) && !bus.flush;
  assign bus.result = result_p1;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (bus.funct3[2]) begin
      a_signed = !bus.funct3[0];
      b_signed = !bus.funct3[0];
    end else begin
      a_signed = bus.funct3[1] ^ bus.funct3[0];
      b_signed = (bus.funct3 == 3'b001);
    end
  end

  assign a_neg    = a_signed && bus.srca[XLEN-1];
  assign b_neg    = b_signed && bus.srcb[XLEN-1];
  assign a_mag    = a_neg ? -bus.srca : bus.srca;
  assign b_mag    = b_neg ? -bus.srcb : bus.srcb;
  assign div_zero = bus.funct3[2] && (bus.srcb == '0);
  assign div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.srca == MIN_NEG) && (bus.srcb == '1);
  assign fast_mul = FAST_MUL && !bus.funct3[2];

  assign a_ext     = {{XLEN{a_signed & bus.srca[XLEN-1]}}, bus.srca};
  assign b_ext     = {{XLEN{b_signed & bus.srcb[XLEN-1]}}, bus.srcb};
  assign fast_prod = a_ext * b_ext;

  always_comb begin
    special_res = (bus.funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    if (div_zero)     special_res = bus.funct3[1] ? bus.srca : '1;
    else if (div_ovf) special_res = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration: multiply uses the low half as the multiplier, divide as the quotient.
  assign mul_sum   = {1'b0, prod_p0[2*XLEN-1:XLEN]} + (prod_p0[0] ? {1'b0, bmag_p0} : '0);
  assign div_shift = {rem_p0[XLEN-1:0], prod_p0[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, bmag_p0};
  assign rem_next  = f3_p0[2] ? (div_diff[XLEN] ? div_shift : div_diff) : rem_p0;
  assign prod_next = f3_p0[2] ? {prod_p0[2*XLEN-1:XLEN], prod_p0[XLEN-2:0], ~div_diff[XLEN]}
                              : {mul_sum, prod_p0[XLEN-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prod_p0   <= '0;
      rem_p0    <= '0;
      bmag_p0   <= '0;
      f3_p0     <= '0;
      neg_q_p0  <= 1'b0;
      neg_r_p0  <= 1'b0;
      result_p1 <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          f3_p0    <= bus.funct3;
          bmag_p0  <= b_mag;
          neg_q_p0 <= a_neg ^ b_neg;
          neg_r_p0 <= a_neg;
          prod_p0  <= {{XLEN{1'b0}}, a_mag};
          rem_p0   <= '0;
          cnt      <= CNT_W'(XLEN);
          if (div_zero || div_ovf || fast_mul) begin
            result_p1 <= special_res;
            state     <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: if (bus.flush) begin
          state <= IDLE;
        end else begin
          prod_p0 <= prod_next;
          rem_p0  <= rem_next;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result_p1 <= finish_op(f3_p0, prod_next, rem_next, neg_q_p0, neg_r_p0);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Bench for mdu_controller: directed vector table, abort/flush/reset sequences,
// randomized operations against an arithmetic reference model, and a FAST_MUL instance.
module tb_mdu_controller;
  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.XLEN(XLEN)) m0 ();
  mdu_if #(.XLEN(XLEN)) m1 ();

  mdu_controller #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(m0.slave));
  mdu_controller #(.XLEN(XLEN), .FAST_MUL(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(m1.slave));

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint ps;
    logic [63:0] pu, pv;
    logic [31:0] r;
    sa = a;
    sb = b;
    pu = {32'b0, a} * {32'b0, b};
    r  = 32'h0;
    case (f3)
      3'd0: r = pu[31:0];
      3'd1: begin ps = longint'(sa) * longint'(sb); pv = ps; r = pv[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); pv = ps; r = pv[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == MINV && b == 32'hFFFF_FFFF) r = MINV;
            else r = sa / sb;
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == MINV && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = sa % sb;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit fast);
    if (f3[2]) return (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF)) ? 1 : XLEN + 1;
    return fast ? 1 : XLEN + 1;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int n, gaps;
    @(negedge clk);
    m0.valid_in = 1'b1; m0.opcode = 7'b0110011; m0.funct7 = 7'b0000001;
    m0.funct3 = f3; m0.srca = a; m0.srcb = b;
    #1 chk({name, "_stall_issue"}, 64'(m0.stall), 64'd1);
    @(posedge clk); #1;
    m0.valid_in = 1'b0;
    n = 1;
    gaps = 0;
    while (m0.done !== 1'b1 && n < 100) begin
      if (m0.stall !== 1'b1) gaps++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_result"}, 64'(m0.result), 64'(exp));
    chk({name, "_stall_in_done"}, 64'(m0.stall), 64'd0);
    chk({name, "_stall_gaps"}, 64'(gaps), 64'd0);
    last_exp = exp;
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 64'(m0.done), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return MINV;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [2:0] f3;
    logic [31:0] a, b;

    vt[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vt[1]  = '{3'd1, MINV,         MINV,          32'h4000_0000, 33};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vt[6]  = '{3'd5, 32'd100,      32'd7,         32'h0000_000E, 33};
    vt[7]  = '{3'd7, 32'd100,      32'd7,         32'h0000_0002, 33};
    vt[8]  = '{3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF, 1};
    vt[9]  = '{3'd6, 32'd5,        32'd0,         32'h0000_0005, 1};
    vt[10] = '{3'd4, MINV,         32'hFFFF_FFFF, MINV,          1};
    vt[11] = '{3'd6, MINV,         32'hFFFF_FFFF, 32'h0,         1};

    reset = 1'b1;
    m0.valid_in = 0; m0.opcode = 0; m0.funct3 = 0; m0.funct7 = 0; m0.srca = 0; m0.srcb = 0; m0.flush = 0;
    m1.valid_in = 0; m1.opcode = 0; m1.funct3 = 0; m1.funct7 = 0; m1.srca = 0; m1.srcb = 0; m1.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 64'(m0.stall), 64'd0);
    chk("reset_done", 64'(m0.done), 64'd0);
    chk("reset_result", 64'(m0.result), 64'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

    // Flush in RUN: DIV issued at T, flush at T+10, MUL at T+12.
    @(negedge clk);
    m0.valid_in = 1; m0.opcode = 7'b0110011; m0.funct7 = 7'b0000001;
    m0.funct3 = 3'd4; m0.srca = 32'd100; m0.srcb = 32'd7;
    @(posedge clk); #1;
    m0.valid_in = 0;
    bad = 0;
    for (int i = 1; i < 10; i++) begin
      if (m0.done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("flush_no_early_done", 64'(bad), 64'd0);
    chk("flush_stall_before", 64'(m0.stall), 64'd1);
    @(negedge clk) m0.flush = 1;
    #1 chk("flush_done_low", 64'(m0.done), 64'd0);
    @(posedge clk); #1;
    m0.flush = 0;
    chk("flush_stall_after", 64'(m0.stall), 64'd0);
    chk("flush_done_after", 64'(m0.done), 64'd0);
    chk("flush_result_kept", 64'(m0.result), 64'(last_exp));
    @(posedge clk); #1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "after_flush_mul");

    // Flush in the DONE cycle suppresses done.
    @(negedge clk);
    m0.valid_in = 1; m0.funct3 = 3'd5; m0.srca = 32'd5; m0.srcb = 32'd0;
    @(posedge clk); #1;
    m0.valid_in = 0;
    chk("flushdone_done_before", 64'(m0.done), 64'd1);
    m0.flush = 1;
    #1 chk("flushdone_done_killed", 64'(m0.done), 64'd0);
    @(posedge clk); #1;
    m0.flush = 0;
    chk("flushdone_idle_stall", 64'(m0.stall), 64'd0);
    chk("flushdone_idle_done", 64'(m0.done), 64'd0);

    // Reset mid-operation.
    @(negedge clk);
    m0.valid_in = 1; m0.funct3 = 3'd1; m0.srca = 32'h1234_5678; m0.srcb = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    m0.valid_in = 0;
    repeat (9) @(posedge clk);
    #1 chk("rstabort_stall_before", 64'(m0.stall), 64'd1);
    @(negedge clk) reset = 1;
    #1;
    chk("rstabort_stall", 64'(m0.stall), 64'd0);
    chk("rstabort_done", 64'(m0.done), 64'd0);
    chk("rstabort_result", 64'(m0.result), 64'd0);
    @(negedge clk) reset = 0;
    run_op(3'd5, 32'd100, 32'd7, 32'h0000_000E, 33, "after_reset_divu");

    // Non-M instructions and flush in IDLE never issue.
    @(negedge clk);
    m0.valid_in = 1; m0.opcode = 7'b0110011; m0.funct7 = 7'b0000000; m0.funct3 = 3'd0;
    #1 chk("add_is_mdu", 64'(m0.is_mdu), 64'd0);
    chk("add_stall", 64'(m0.stall), 64'd0);
    bad = 0;
    repeat (4) begin @(posedge clk); #1; if (m0.done !== 1'b0 || m0.stall !== 1'b0) bad++; end
    chk("add_no_activity", 64'(bad), 64'd0);
    m0.opcode = 7'b0010011; m0.funct7 = 7'b0000001;
    #1 chk("opimm_is_mdu", 64'(m0.is_mdu), 64'd0);
    m0.opcode = 7'b0110011; m0.funct3 = 3'd5; m0.srca = 32'd9; m0.srcb = 32'd0; m0.flush = 1;
    #1 chk("idleflush_is_mdu", 64'(m0.is_mdu), 64'd1);
    chk("idleflush_stall", 64'(m0.stall), 64'd0);
    bad = 0;
    repeat (3) begin @(posedge clk); #1; if (m0.done !== 1'b0) bad++; end
    chk("idleflush_no_done", 64'(bad), 64'd0);
    m0.valid_in = 0; m0.flush = 0;

    // Randomized operations, issued back to back.
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(f3, a, b, model_result(f3, a, b), model_latency(f3, a, b, 1'b0), $sformatf("rand%0d_f%0d", i, f3));
    end

    // FAST_MUL instance: multiplies finish one cycle after issue.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin f3 = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; end
      else begin f3 = 3'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand(); end
      @(negedge clk);
      m1.valid_in = 1; m1.opcode = 7'b0110011; m1.funct7 = 7'b0000001;
      m1.funct3 = f3; m1.srca = a; m1.srcb = b;
      #1 chk($sformatf("fast%0d_stall", i), 64'(m1.stall), 64'd1);
      @(posedge clk); #1;
      m1.valid_in = 0;
      chk($sformatf("fast%0d_done", i), 64'(m1.done), 64'd1);
      chk($sformatf("fast%0d_result", i), 64'(m1.result), 64'(model_result(f3, a, b)));
      chk($sformatf("fast%0d_stall_done", i), 64'(m1.stall), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("fast%0d_done_pulse", i), 64'(m1.done), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
